// File: rtl/expedidor_pkg.sv
// Shared definitions for the dozen dispatcher: FSM state encoding and widths.
package expedidor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } estado_t;

  localparam int W_DUZIAS = 4;
  localparam int W_SUB    = 3;
  localparam int W_GAP    = 4;

endpackage

// File: rtl/expedidor_duzias_temporizador.sv
// Loadable down-counter that times the idle gap between release pulses.
// After a load, o_fim is high for exactly one cycle, INTERVALO cycles later.
module temporizador_intervalo
  import expedidor_pkg::*;
#(
  parameter int INTERVALO = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_carga,
  input  logic i_limpa,
  output logic o_fim
);

  localparam logic [W_GAP-1:0] CARGA = W_GAP'(INTERVALO - 1);

  logic [W_GAP-1:0] r_cont;
  logic             r_ativo;

  // Count down from INTERVALO-1 once loaded; disarm after reaching zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cont  <= '0;
      r_ativo <= 1'b0;
    end else if (i_limpa) begin
      r_cont  <= '0;
      r_ativo <= 1'b0;
    end else if (i_carga) begin
      r_cont  <= CARGA;
      r_ativo <= 1'b1;
    end else if (r_ativo) begin
      if (r_cont == '0) r_ativo <= 1'b0;
      else              r_cont  <= r_cont - 1'b1;
    end
  end

  assign o_fim = r_ativo && (r_cont == '0);

endmodule

// File: rtl/expedidor_duzias.sv
// Dozen dispatcher: turns a requested number of dozens into a spaced train of
// bottle-release pulses, counting the remaining dozens down to zero.
module expedidor_duzias
  import expedidor_pkg::*;
#(
  parameter int MAX_DUZIAS       = 9,
  parameter int PULSOS_POR_DUZIA = 6,
  parameter int INTERVALO        = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [W_DUZIAS-1:0] qtd_duzias,
  input  logic                abort,
  output logic                pulso,
  output logic [W_DUZIAS-1:0] restante,
  output logic                busy,
  output logic                done,
  output logic                erro
);

  localparam logic [W_SUB-1:0]    SUB_ULT = W_SUB'(PULSOS_POR_DUZIA - 1);
  localparam logic [W_DUZIAS-1:0] MAX_Q   = W_DUZIAS'(MAX_DUZIAS);

  estado_t             r_estado;
  logic [W_SUB-1:0]    r_sub;
  logic [W_DUZIAS-1:0] r_restante;
  logic                r_pulso;
  logic                r_busy;
  logic                r_done;
  logic                r_erro;

  logic w_ult_pulso;
  logic w_ult_duzia;
  logic w_em_curso;
  logic w_carga;
  logic w_limpa;
  logic w_gap_fim;

  assign w_ult_pulso = (r_sub == SUB_ULT);
  assign w_ult_duzia = w_ult_pulso && (r_restante == W_DUZIAS'(1));
  assign w_em_curso  = (r_estado == PULSE) || (r_estado == GAP);
  // Arm the gap timer on every pulse that is not the final one of the dispatch.
  assign w_carga     = (r_estado == PULSE) && !abort && !w_ult_duzia;
  assign w_limpa     = w_em_curso && abort;

  temporizador_intervalo #(
    .INTERVALO(INTERVALO)
  ) u_gap (
    .clk    (clk),
    .reset  (reset),
    .i_carga(w_carga),
    .i_limpa(w_limpa),
    .o_fim  (w_gap_fim)
  );

  // Dispatch FSM with the dozen/sub-pulse counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado   <= IDLE;
      r_sub      <= '0;
      r_restante <= '0;
      r_pulso    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_erro <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (start) begin
            if (qtd_duzias > MAX_Q) begin
              r_erro <= 1'b1;
            end else if (qtd_duzias == '0) begin
              r_done     <= 1'b1;
              r_restante <= '0;
            end else begin
              r_restante <= qtd_duzias;
              r_sub      <= '0;
              r_estado   <= PULSE;
              r_pulso    <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        PULSE: begin
          r_pulso <= 1'b0;
          if (abort) begin
            r_estado <= IDLE;
            r_busy   <= 1'b0;
            r_sub    <= '0;
          end else if (w_ult_pulso) begin
            r_sub      <= '0;
            r_restante <= r_restante - 1'b1;
            if (w_ult_duzia) begin
              r_estado <= FIN;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_estado <= GAP;
            end
          end else begin
            r_sub    <= r_sub + 1'b1;
            r_estado <= GAP;
          end
        end
        GAP: begin
          if (abort) begin
            r_estado <= IDLE;
            r_busy   <= 1'b0;
            r_sub    <= '0;
          end else if (w_gap_fim) begin
            r_estado <= PULSE;
            r_pulso  <= 1'b1;
          end
        end
        FIN: begin
          r_estado <= IDLE;
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  assign pulso    = r_pulso;
  assign restante = r_restante;
  assign busy     = r_busy;
  assign done     = r_done;
  assign erro     = r_erro;

endmodule

// File: tb/tb_expedidor_duzias.sv
// Bench for expedidor_duzias: timing model derived from the pulse formula,
// checked every cycle, plus literal expectations per scenario.
module tb_expedidor_duzias;

  localparam int MAXD = 9;
  localparam int PPD  = 6;
  localparam int INT  = 2;
  localparam int P    = INT + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] qtd = 4'd0;
  logic       pulso, busy, done, erro;
  logic [3:0] restante;

  expedidor_duzias #(
    .MAX_DUZIAS(MAXD), .PULSOS_POR_DUZIA(PPD), .INTERVALO(INT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .qtd_duzias(qtd), .abort(abort),
    .pulso(pulso), .restante(restante), .busy(busy), .done(done), .erro(erro)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: cycle d (d=1 is the cycle after the start edge) carries pulse k
  // when d = 1+(k-1)*P; done follows the last pulse.
  logic       m_pulso = 0, m_busy = 0, m_done = 0, m_erro = 0, m_run = 0, m_fin = 0;
  logic [3:0] m_rest = 0;
  int         m_q = 0, m_n = 0, m_d = 0;

  always @(posedge clk or posedge reset) begin : model
    int d, L, nq, nn;
    logic np, nb, nd, ne, nr, nf;
    logic [3:0] nrest;
    if (reset) begin
      m_pulso <= 0; m_busy <= 0; m_done <= 0; m_erro <= 0;
      m_run <= 0; m_fin <= 0; m_rest <= 0; m_q <= 0; m_n <= 0; m_d <= 0;
    end else begin
      np = m_pulso; nb = m_busy; nd = 0; ne = 0; nf = 0; nr = m_run;
      nrest = m_rest; nq = m_q; nn = m_n; d = m_d;
      if (m_run && abort) begin
        nr = 0; np = 0; nb = 0;
      end else begin
        if (!m_run && !m_fin && start) begin
          if (int'(qtd) > MAXD) ne = 1;
          else if (qtd == 0) begin nd = 1; nrest = 0; end
          else begin nr = 1; nq = int'(qtd); nn = int'(qtd) * PPD; d = 0; end
        end
        if (nr) begin
          d = d + 1;
          L = 1 + (nn - 1) * P;
          if (d <= L) begin
            np = ((d - 1) % P) == 0;
            nb = 1;
            nrest = 4'(nq - ((d - 1 + P - 1) / P) / PPD);
          end else begin
            nr = 0; nd = 1; nf = 1; nb = 0; np = 0; nrest = 0;
          end
        end
      end
      m_pulso <= np; m_busy <= nb; m_done <= nd; m_erro <= ne; m_run <= nr;
      m_fin <= nf; m_rest <= nrest; m_q <= nq; m_n <= nn; m_d <= d;
    end
  end

  int   total = 0, bad = 0;
  int   pcnt = 0, dcnt = 0, ecnt = 0, bcnt = 0, last_p = 0, last_d = 0;
  logic chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_start(input logic [3:0] q, input logic ab, output int t);
    @(negedge clk);
    start = 1; qtd = q; abort = ab; t = cyc;
    @(negedge clk);
    start = 0; abort = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pulso"}, int'(pulso), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_erro"}, int'(erro), 0);
    chk({tag, "_restante"}, int'(restante), 0);
  endtask

  initial begin
    int t, p0, d0, e0, b0;
    bit hit;
    #1;
    chk_zero("reset");

    fork
      forever begin
        @(negedge clk);
        if (chk_en && !reset) begin
          chk("cyc_pulso", int'(pulso), int'(m_pulso));
          chk("cyc_busy", int'(busy), int'(m_busy));
          chk("cyc_done", int'(done), int'(m_done));
          chk("cyc_erro", int'(erro), int'(m_erro));
          chk("cyc_restante", int'(restante), int'(m_rest));
          if (pulso) begin pcnt++; last_p = cyc; end
          if (done) begin dcnt++; last_d = cyc; end
          if (erro) ecnt++;
          if (busy) bcnt++;
        end
      end
    join_none

    @(negedge clk); @(negedge clk);
    reset = 0; chk_en = 1;

    // qtd=2 with a re-start of qtd=5 while busy
    p0 = pcnt; b0 = bcnt; d0 = dcnt;
    do_start(4'd2, 1'b0, t);
    repeat (5) @(negedge clk);
    do_start(4'd5, 1'b0, e0);
    repeat (40) @(negedge clk);
    chk("q2_pulses", pcnt - p0, 12);
    chk("q2_last_pulse", last_p - t, 34);
    chk("q2_done_cycle", last_d - t, 35);
    chk("q2_busy_cycles", bcnt - b0, 34);
    chk("q2_done_count", dcnt - d0, 1);
    chk("q2_restante", int'(restante), 0);

    // qtd=0: immediate done
    p0 = pcnt; d0 = dcnt; b0 = bcnt;
    do_start(4'd0, 1'b0, t);
    @(negedge clk);
    chk("q0_done", dcnt - d0, 1);
    chk("q0_pulses", pcnt - p0, 0);
    chk("q0_busy", bcnt - b0, 0);

    // qtd=3, abort after pulse 8
    p0 = pcnt; d0 = dcnt;
    do_start(4'd3, 1'b0, t);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pcnt - p0 >= 8) begin hit = 1; break; end
    end
    if (!hit) chk("abort_wait_timeout", 0, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    repeat (20) @(negedge clk);
    chk("abort_pulses", pcnt - p0, 8);
    chk("abort_restante", int'(restante), 2);
    chk("abort_no_done", dcnt - d0, 0);
    chk("abort_busy", int'(busy), 0);

    // qtd=10: rejected, restante kept
    p0 = pcnt; e0 = ecnt;
    do_start(4'd10, 1'b0, t);
    @(negedge clk);
    chk("q10_erro", ecnt - e0, 1);
    chk("q10_pulses", pcnt - p0, 0);
    chk("q10_restante", int'(restante), 2);

    // qtd=1 with abort high alongside start: start wins
    p0 = pcnt; d0 = dcnt;
    do_start(4'd1, 1'b1, t);
    repeat (25) @(negedge clk);
    chk("q1_pulses", pcnt - p0, 6);
    chk("q1_done", dcnt - d0, 1);
    chk("q1_done_cycle", last_d - t, 17);

    // qtd=9 boundary
    p0 = pcnt; d0 = dcnt;
    do_start(4'd9, 1'b0, t);
    repeat (170) @(negedge clk);
    chk("q9_pulses", pcnt - p0, 54);
    chk("q9_done_cycle", last_d - t, 161);
    chk("q9_done", dcnt - d0, 1);
    chk("q9_restante", int'(restante), 0);

    // reset during a gap, then a fresh dispatch
    do_start(4'd2, 1'b0, t);
    @(negedge clk);
    reset = 1;
    #1;
    chk_zero("midreset");
    @(negedge clk); @(negedge clk);
    reset = 0;
    p0 = pcnt; d0 = dcnt;
    do_start(4'd1, 1'b0, t);
    repeat (25) @(negedge clk);
    chk("post_reset_pulses", pcnt - p0, 6);
    chk("post_reset_done", dcnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expedidor_duzias.md
Name: expedidor_duzias

Overview:
- Dispatch-side counterpart of the dozen counter on the wine conveyor.
- Takes a requested number of dozens and generates the bottle-release pulse train for them: PULSOS_POR_DUZIA pulses per dozen, spaced by INTERVALO idle cycles.
- Counts the remaining dozens down to zero, then signals completion.
- Drives the output-gate actuator; the operator panel reads `restante`.

Parameters:
- MAX_DUZIAS, 9: largest accepted request; requests above it are rejected.
- PULSOS_POR_DUZIA, 6: release pulses emitted per dozen. Legal range 1..7.
- INTERVALO, 2: idle cycles between consecutive pulses. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  dispatch request; sampled only in IDLE
- qtd_duzias  in  4  dozens to dispatch; sampled with start
- abort  in  1  synchronous cancel of a dispatch in progress
- pulso  out  1  bottle-release pulse, one cycle wide, registered
- restante  out  4  dozens not yet fully dispatched, registered
- busy  out  1  high while a dispatch is in progress
- done  out  1  one-cycle completion strobe
- erro  out  1  one-cycle strobe: request rejected (qtd_duzias > MAX_DUZIAS)

Behaviour:
- Reset (asynchronous, any state): state=IDLE; pulso, done, erro, busy = 0; restante = 0; pulse sub-counter = 0; gap counter = 0.
- All outputs are registered. busy = (state is PULSE or GAP).
- Internal counters: 3-bit pulse sub-counter, 4-bit gap counter.
- IDLE, start=1 at edge T:
  - qtd_duzias > MAX_DUZIAS: erro=1 for the cycle after T; restante unchanged; stay IDLE.
  - qtd_duzias == 0: done=1 for the cycle after T; no pulses; restante=0; stay IDLE.
  - Otherwise: restante <= qtd_duzias; sub-counter <= 0; go to PULSE. pulso is high in the cycle after T.
- PULSE (one cycle, pulso=1):
  - sub-counter increments.
  - On the last pulse of a dozen (sub-counter == PULSOS_POR_DUZIA-1): sub-counter <= 0 and restante <= restante-1.
  - If that dozen was the last one (restante == 1): go to FIN. Otherwise go to GAP.
- GAP: pulso=0 for exactly INTERVALO cycles, then PULSE. Pulse period is 1+INTERVALO cycles.
- FIN: done=1 for one cycle, restante=0, busy=0, then IDLE. A start sampled during FIN is ignored.
- start while busy: ignored. The request is not queued.
- abort=1 while in PULSE or GAP: next state IDLE; pulso=0 from the next cycle; no done pulse.
  - restante keeps its current value, so the operator sees the dozens not fully sent.
  - sub-counter is cleared.
  - abort in IDLE has no effect.
- abort and start both high in IDLE: start wins (abort is a no-op in IDLE).
- Timing for N = qtd_duzias × PULSOS_POR_DUZIA pulses, start sampled at edge T:
  - first pulso in cycle T+1;
  - k-th pulso in cycle T+1+(k-1)(1+INTERVALO);
  - done in the cycle after the last pulse.
- Width rules:
  - restante never wraps below 0.
  - The sub-counter must hold PULSOS_POR_DUZIA-1, hence the limit of 7.
  - INTERVALO fits the 4-bit gap counter, hence the limit of 15.

Decomposition:
- Shared package expedidor_pkg holds:
  - the state encoding (IDLE, PULSE, GAP, FIN) as a 2-bit enum;
  - the width constants W_DUZIAS=4, W_SUB=3, W_GAP=4.
- One natural sub-module, temporizador_intervalo: a loadable down-counter that raises a one-cycle terminal flag after INTERVALO cycles. It is used for the GAP state.
- The FSM and the dozen/sub counters stay in the top module.

Test Plan:
- Reset mid-dispatch: assert reset during a GAP → all outputs 0 immediately; a fresh start afterwards behaves normally.
- Defaults, qtd=2: start at T → 12 pulses at T+1, T+4, …, T+34. restante steps 2→1 after pulse 6 and 1→0 after pulse 12. done in T+35; busy high T+1..T+34.
- qtd=0: start → done the next cycle, no pulso, busy never high. qtd=10: start → erro the next cycle, no pulso, restante unchanged.
- Abort: qtd=3, abort after pulse 8 → no further pulses, restante=2 held, no done; the next start with qtd=1 gives exactly 6 pulses.
- start re-asserted while busy with qtd=5 → ignored; original pulse count and restante sequence unchanged.
- qtd=9 (boundary) → 54 pulses, restante counts 9 down to 0, done after the last pulse.
